// File: rtl/cart_dl_pkg.sv
// cart_dl_pkg: shared definitions for the cartridge download scanner.
//   dl_state_e  - scanner FSM states
//   Hdr*        - byte offsets of the header words captured during download
//   LogoBase    - byte offset of the first reference logo word
package cart_dl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StResolve,
        StDone
    } dl_state_e;

    localparam logic [11:0] HdrCgb   = 12'h142;
    localparam logic [11:0] HdrType  = 12'h146;
    localparam logic [11:0] HdrSize  = 12'h148;
    localparam logic [11:0] HdrLic   = 12'h14A;
    localparam logic [11:0] LogoBase = 12'h104;

endpackage

// File: rtl/cart_logo_probe.sv
// cart_logo_probe: logo comparison for one probe bank.
//   clk_sys, reset - system clock, synchronous active-high reset
//   clear          - drop all probe state (start of a new download)
//   resolve        - latch the match result from the accumulated state
//   wr             - capture write whose word index falls inside the logo
//   page           - ioctl_addr[ADDR_W-1:12] of that write
//   data           - written word
//   logo_word      - reference logo word at the same index
//   match          - every logo word was seen at this bank and none differed
module cart_logo_probe #(
    parameter int unsigned ADDR_W     = 25,
    parameter int unsigned LOGO_WORDS = 8,
    parameter int unsigned BASE       = 32'h40000
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              clear,
    input  logic              resolve,
    input  logic              wr,
    input  logic [ADDR_W-13:0] page,
    input  logic [15:0]       data,
    input  logic [15:0]       logo_word,
    output logic              match
);

    localparam int unsigned       CntW     = $clog2(LOGO_WORDS + 1);
    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE);
    localparam logic [CntW-1:0]   CntFull  = CntW'(LOGO_WORDS);

    logic [CntW-1:0] cnt_q;
    logic            mism_q;
    logic            match_q;
    logic            hit;

    assign hit = wr && (page == BaseAddr[ADDR_W-1:12]);

    always_ff @(posedge clk_sys) begin
        if (reset || clear) begin
            cnt_q   <= '0;
            mism_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            if (hit) begin
                // Saturation lets duplicate writes through without
                // turning a full count into a wrapped one.
                if (cnt_q != CntFull) cnt_q <= cnt_q + CntW'(1);
                if (data != logo_word) mism_q <= 1'b1;
            end
            if (resolve) match_q <= (cnt_q == CntFull) && !mism_q;
        end
    end

    assign match = match_q;

endmodule

// File: rtl/cart_dl_scanner.sv
// cart_dl_scanner: paces ioctl ROM download writes into SDRAM, captures the
// cartridge header and reference logo, and checks for logo copies at
// NUM_PROBES bank offsets to detect multicart images.
//   clk_sys, reset      - system clock, synchronous active-high reset
//   ce                  - CPU clock enable
//   cart_download       - ROM download in progress
//   ioctl_wr/addr/dout  - download write strobe, byte address, data word
//   ioctl_wait          - download stall until the SDRAM write is done
//   dn_write            - SDRAM write request (ce-time)
//   cart_ready          - at least one word committed since reset
//   overrun             - sticky: a write arrived while stalled
//   mbc_type .. old_licensee - captured header fields
//   rom_mask            - highest ioctl_addr[22:14] seen
//   logo_match          - per-probe logo match result
//   scan_done           - results valid
module cart_dl_scanner
    import cart_dl_pkg::*;
#(
    parameter int unsigned ADDR_W      = 25,
    parameter int unsigned LOGO_WORDS  = 8,
    parameter int unsigned NUM_PROBES  = 4,
    parameter int unsigned PROBE_SHIFT = 18
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  cart_download,
    input  logic                  ioctl_wr,
    input  logic [ADDR_W-1:0]     ioctl_addr,
    input  logic [15:0]           ioctl_dout,
    output logic                  ioctl_wait,
    output logic                  dn_write,
    output logic                  cart_ready,
    output logic                  overrun,
    output logic [7:0]            mbc_type,
    output logic [7:0]            sgb_flag,
    output logic                  cgb_flag,
    output logic [7:0]            rom_size,
    output logic [7:0]            ram_size,
    output logic [7:0]            old_licensee,
    output logic [8:0]            rom_mask,
    output logic [NUM_PROBES-1:0] logo_match,
    output logic                  scan_done
);

    localparam int unsigned IdxW = (LOGO_WORDS > 1) ? $clog2(LOGO_WORDS) : 1;

    dl_state_e   state_q;
    logic        dl_q;
    logic        wait_q, dn_write_q, ready_q, overrun_q, scan_done_q;
    logic [7:0]  mbc_type_q, sgb_flag_q, rom_size_q, ram_size_q, lic_q;
    logic        cgb_q;
    logic [8:0]  rom_mask_q;
    logic [15:0] logo_q [LOGO_WORDS];

    logic            dl_rise, start, cap_wr, page0, logo_hit;
    logic [10:0]     logo_i;
    logic [IdxW-1:0] logo_idx;

    assign dl_rise  = cart_download && !dl_q;
    assign start    = dl_rise && ((state_q == StIdle) || (state_q == StDone));
    assign cap_wr   = (state_q == StCapture) && cart_download && ioctl_wr;
    assign page0    = (ioctl_addr[ADDR_W-1:12] == '0);
    // Addresses below LogoBase wrap to a large index and fall out of range.
    assign logo_i   = 11'((ioctl_addr[11:0] - LogoBase) >> 1);
    assign logo_hit = (32'(logo_i) < LOGO_WORDS);
    assign logo_idx = logo_i[IdxW-1:0];

    // Write handshake: a strobe stalls the bus, the next ce raises dn_write,
    // the ce after that retires it. A new strobe always wins over the retire.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wait_q     <= 1'b0;
            dn_write_q <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            if (ce) begin
                dn_write_q <= wait_q;
                if (dn_write_q) begin
                    wait_q     <= 1'b0;
                    dn_write_q <= 1'b0;
                    ready_q    <= 1'b1;
                end
            end
            if (ioctl_wr) wait_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= StIdle;
            // Treat the download line as already high so a download that
            // was in flight across reset is not picked up half-way.
            dl_q        <= 1'b1;
            overrun_q   <= 1'b0;
            scan_done_q <= 1'b0;
            mbc_type_q  <= '0;
            sgb_flag_q  <= '0;
            cgb_q       <= 1'b0;
            rom_size_q  <= '0;
            ram_size_q  <= '0;
            lic_q       <= '0;
            rom_mask_q  <= '0;
            for (int i = 0; i < int'(LOGO_WORDS); i++) logo_q[i] <= '0;
        end else begin
            dl_q <= cart_download;
            if (ioctl_wr && wait_q) overrun_q <= 1'b1;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q     <= StCapture;
                        overrun_q   <= 1'b0;
                        scan_done_q <= 1'b0;
                        mbc_type_q  <= '0;
                        sgb_flag_q  <= '0;
                        cgb_q       <= 1'b0;
                        rom_size_q  <= '0;
                        ram_size_q  <= '0;
                        lic_q       <= '0;
                        rom_mask_q  <= '0;
                        for (int i = 0; i < int'(LOGO_WORDS); i++) logo_q[i] <= '0;
                    end
                end
                StCapture: begin
                    if (cap_wr) begin
                        if (ioctl_addr[22:14] > rom_mask_q) rom_mask_q <= ioctl_addr[22:14];
                        if (page0) begin
                            case (ioctl_addr[11:0])
                                HdrCgb:  cgb_q <= ioctl_dout[15];
                                HdrType: {mbc_type_q, sgb_flag_q} <= ioctl_dout;
                                HdrSize: {ram_size_q, rom_size_q} <= ioctl_dout;
                                HdrLic:  lic_q <= ioctl_dout[15:8];
                                default: ;
                            endcase
                            if (logo_hit) logo_q[logo_idx] <= ioctl_dout;
                        end
                    end
                    if (!cart_download) state_q <= StResolve;
                end
                StResolve: begin
                    state_q     <= StDone;
                    scan_done_q <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    for (genvar k = 0; k < int'(NUM_PROBES); k++) begin : g_probe
        cart_logo_probe #(
            .ADDR_W     (ADDR_W),
            .LOGO_WORDS (LOGO_WORDS),
            .BASE       ((k + 1) << PROBE_SHIFT)
        ) u_probe (
            .clk_sys   (clk_sys),
            .reset     (reset),
            .clear     (start),
            .resolve   (state_q == StResolve),
            .wr        (cap_wr && logo_hit),
            .page      (ioctl_addr[ADDR_W-1:12]),
            .data      (ioctl_dout),
            .logo_word (logo_q[logo_idx]),
            .match     (logo_match[k])
        );
    end

    assign ioctl_wait   = wait_q;
    assign dn_write     = dn_write_q;
    assign cart_ready   = ready_q;
    assign overrun      = overrun_q;
    assign mbc_type     = mbc_type_q;
    assign sgb_flag     = sgb_flag_q;
    assign cgb_flag     = cgb_q;
    assign rom_size     = rom_size_q;
    assign ram_size     = ram_size_q;
    assign old_licensee = lic_q;
    assign rom_mask     = rom_mask_q;
    assign scan_done    = scan_done_q;

endmodule
